// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register with direct-mapped BTB next-PC prediction
module fetch_pc_gen #(
  parameter int ADDR_W = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              pred_taken,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_taken,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  output logic              fetch_pred_taken,
  output logic [ADDR_W-1:0] fetch_pred_target
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic                   fv_q;
  logic [IDX_W-1:0]       rd_idx, wr_idx;
  logic                   hit, wr_en;
  assign rd_idx = pc_q[IDX_W+1:2];
  assign wr_idx = update_pc[IDX_W+1:2];
  assign wr_en = update_valid & update_taken;
  assign hit = valid_q[rd_idx] & (tag_q[rd_idx] == pc_q[ADDR_W-1:IDX_W+2]);
  assign fetch_pc = pc_q;
  assign fetch_valid = fv_q;
  assign fetch_pred_taken = hit & pred_taken;
  assign fetch_pred_target = fetch_pred_taken ? tgt_q[rd_idx] : pc_q + ADDR_W'(4);
  // next PC: redirect beats stall; PC holds on the first cycle out of reset
  always_comb begin
    pc_d = redirect_valid ? redirect_pc : (stall | ~fv_q) ? pc_q : fetch_pred_target;
  end
  // PC, fetch-valid and BTB valid bits; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      fv_q <= 1'b0;
      valid_q <= '0;
    end else begin
      pc_q <= pc_d;
      fv_q <= 1'b1;
      if (wr_en) valid_q[wr_idx] <= 1'b1;
    end
  end
  // BTB tag/target storage; only taken branches allocate
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= update_pc[ADDR_W-1:IDX_W+2];
      tgt_q[wr_idx] <= update_target;
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: table-driven directed checks of fetch_pc_gen
module tb_fetch_pc_gen;
  logic        clk = 0, rst, stall, pred_taken, redirect_valid, update_valid, update_taken;
  logic [31:0] redirect_pc, update_pc, update_target;
  logic [31:0] fetch_pc, fetch_pred_target;
  logic        fetch_valid, fetch_pred_taken;
  int          n_chk = 0, n_pass = 0;

  typedef struct {
    logic r, s, p, rv;
    logic [31:0] rpc;
    logic uv;
    logic [31:0] upc, utgt;
    logic ut;
    logic efv;
    logic [31:0] epc;
    logic ept;
    logic [31:0] etgt;
  } vec_t;

  vec_t tv[$];

  fetch_pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .pred_taken(pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, s, p, rv, input logic [31:0] rpc,
                              input logic uv, input logic [31:0] upc, utgt, input logic ut,
                              input logic efv, input logic [31:0] epc, input logic ept,
                              input logic [31:0] etgt);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.rv = rv; v.rpc = rpc;
    v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut;
    v.efv = efv; v.epc = epc; v.ept = ept; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h want %h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; stall = v.s; pred_taken = v.p; redirect_valid = v.rv; redirect_pc = v.rpc;
    update_valid = v.uv; update_pc = v.upc; update_target = v.utgt; update_taken = v.ut;
  endtask

  initial begin
    //            r  s  p  rv rpc           uv upc    utgt   ut  fv pc            pt tgt
    tv.push_back(mk(1, 0, 0, 0, 0,          0, 0,     0,     0,  0, 32'h0,        0, 32'h4));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 0,     0,     0,  0, 32'h0,        0, 32'h4));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 0,     0,     0,  1, 32'h0,        0, 32'h4));
    tv.push_back(mk(0, 0, 0, 0, 0,          1, 32'h10, 32'h80, 1, 1, 32'h4,       0, 32'h8));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 0,     0,     0,  1, 32'h8,        0, 32'hC));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 0,     0,     0,  1, 32'hC,        0, 32'h10));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h10,       1, 32'h80));
    tv.push_back(mk(0, 0, 0, 1, 32'h10,     0, 0,     0,     0,  1, 32'h80,       0, 32'h84));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 0,     0,     0,  1, 32'h10,       0, 32'h14));
    tv.push_back(mk(0, 0, 0, 1, 32'h50,     0, 0,     0,     0,  1, 32'h14,       0, 32'h18));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h50,       0, 32'h54));
    tv.push_back(mk(0, 1, 0, 1, 32'h200,    0, 0,     0,     0,  1, 32'h54,       0, 32'h58));
    tv.push_back(mk(0, 1, 0, 0, 0,          0, 0,     0,     0,  1, 32'h200,      0, 32'h204));
    tv.push_back(mk(0, 1, 0, 0, 0,          0, 0,     0,     0,  1, 32'h200,      0, 32'h204));
    tv.push_back(mk(0, 1, 0, 0, 0,          0, 0,     0,     0,  1, 32'h200,      0, 32'h204));
    tv.push_back(mk(0, 0, 0, 1, 32'h20,     0, 0,     0,     0,  1, 32'h200,      0, 32'h204));
    tv.push_back(mk(0, 0, 1, 0, 0,          1, 32'h20, 32'h40, 1, 1, 32'h20,      0, 32'h24));
    tv.push_back(mk(0, 0, 0, 1, 32'h20,     0, 0,     0,     0,  1, 32'h24,       0, 32'h28));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h20,       1, 32'h40));
    tv.push_back(mk(0, 0, 0, 1, 32'hFFFFFFFC, 0, 0,   0,     0,  1, 32'h40,       0, 32'h44));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'hFFFFFFFC, 0, 32'h0));
    tv.push_back(mk(0, 0, 0, 0, 0,          1, 32'h0, 32'h100, 0, 1, 32'h0,       0, 32'h4));
    tv.push_back(mk(0, 0, 0, 1, 32'h0,      0, 0,     0,     0,  1, 32'h4,        0, 32'h8));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h0,        0, 32'h4));
    tv.push_back(mk(0, 1, 0, 1, 32'h10,     1, 32'h30, 32'h300, 1, 1, 32'h4,      0, 32'h8));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h10,       1, 32'h80));
    tv.push_back(mk(0, 0, 0, 1, 32'h30,     0, 0,     0,     0,  1, 32'h80,       0, 32'h84));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h30,       1, 32'h300));
    tv.push_back(mk(1, 0, 0, 1, 32'h10,     0, 0,     0,     0,  1, 32'h300,      0, 32'h304));
    tv.push_back(mk(0, 0, 0, 0, 0,          0, 0,     0,     0,  0, 32'h0,        0, 32'h4));
    tv.push_back(mk(0, 0, 0, 1, 32'h10,     0, 0,     0,     0,  1, 32'h0,        0, 32'h4));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h10,       0, 32'h14));
    tv.push_back(mk(0, 0, 0, 1, 32'h30,     0, 0,     0,     0,  1, 32'h14,       0, 32'h18));
    tv.push_back(mk(0, 0, 1, 0, 0,          0, 0,     0,     0,  1, 32'h30,       0, 32'h34));

    drive(tv[0]);
    @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk("fetch_valid", i, 32'(fetch_valid), 32'(tv[i].efv));
      chk("fetch_pc", i, fetch_pc, tv[i].epc);
      chk("fetch_pred_taken", i, 32'(fetch_pred_taken), 32'(tv[i].ept));
      chk("fetch_pred_target", i, fetch_pred_target, tv[i].etgt);
    end

    // reset asserted during a stall with a pending redirect
    @(negedge clk);
    drive(mk(0, 0, 0, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1 chk("seq_redirect_pc", 100, fetch_pc, 32'h400);
    drive(mk(1, 1, 0, 1, 32'h500, 1, 32'h400, 32'h800, 1, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("seq_rst_stall_pc", 101, fetch_pc, 32'h0);
    chk("seq_rst_stall_fv", 101, 32'(fetch_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("seq_stall_hold_fv", 102, 32'(fetch_valid), 32'h1);
    chk("seq_stall_hold_pc", 102, fetch_pc, 32'h0);
    @(negedge clk);
    #1 chk("seq_stall_hold2_pc", 103, fetch_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
